max_frame_collector: RTL and testbench

Streaming front end for `max_finder`. Accepts scalar samples over a valid/ready handshake, packs N consecutive samples into a frame buffer, and hands the frame to a `max_finder` instance. It then presents the index and value of the frame maximum as one registered result beat over a second valid/ready handshake. The block sits between a sample source (ADC or accumulator stream) and any consumer of per-frame argmax results.

---
 rtl/max_finder_pkg.sv | 13 +
 rtl/max_finder.sv | 48 ++++
 rtl/max_frame_collector.sv | 106 ++++++++++
 tb/tb_max_frame_collector.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_finder_pkg.sv
// Shared types and helpers for the frame collector and its argmax tree.
package max_finder_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    RESULT = 1'b1
  } state_t;

  function automatic int calc_index_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_finder.sv
// Combinational argmax over N unsigned values; a balanced compare tree where
// the lower index wins every tie.
module max_finder
  import max_finder_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int N           = 8,
  parameter int INDEX_WIDTH = calc_index_width(N)
) (
  input  logic [VALUE_WIDTH-1:0] i_data [N],
  output logic [INDEX_WIDTH-1:0] o_index
);

  // Leaves padded to a power of two; padded leaves never win a compare.
  localparam int P = (N == 1) ? 1 : (1 << $clog2(N));

  logic [VALUE_WIDTH-1:0] w_val [1:2*P-1];
  logic [INDEX_WIDTH-1:0] w_idx [1:2*P-1];
  logic                   w_vld [1:2*P-1];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < N) begin : g_real
        assign w_val[P+gi] = i_data[gi];
        assign w_idx[P+gi] = INDEX_WIDTH'(gi);
        assign w_vld[P+gi] = 1'b1;
      end else begin : g_pad
        assign w_val[P+gi] = '0;
        assign w_idx[P+gi] = '0;
        assign w_vld[P+gi] = 1'b0;
      end
    end

    // Heap layout: node k merges children 2k (lower indices) and 2k+1.
    for (gi = 1; gi < P; gi++) begin : g_node
      logic w_take_right;
      assign w_take_right = w_vld[2*gi+1] &&
                            (!w_vld[2*gi] || (w_val[2*gi+1] > w_val[2*gi]));
      assign w_val[gi] = w_take_right ? w_val[2*gi+1] : w_val[2*gi];
      assign w_idx[gi] = w_take_right ? w_idx[2*gi+1] : w_idx[2*gi];
      assign w_vld[gi] = w_vld[2*gi] | w_vld[2*gi+1];
    end
  endgenerate

  assign o_index = w_idx[1];

endmodule

// File: rtl/max_frame_collector.sv
// Packs N handshaked samples into a frame and returns the frame's argmax
// (index and value) as one registered result beat.
module max_frame_collector
  import max_finder_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int N           = 8,
  parameter int INDEX_WIDTH = calc_index_width(N)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [VALUE_WIDTH-1:0] i_value,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [VALUE_WIDTH-1:0] o_value
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [INDEX_WIDTH-1:0] r_count;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [VALUE_WIDTH-1:0] r_buffer [N];
  logic [VALUE_WIDTH-1:0] w_frame  [N];
  logic [INDEX_WIDTH-1:0] w_max_idx;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_result_taken;

  // Handshake outputs see only state and rst/clear, so a cleared result
  // can never look like a completed handshake to the consumer.
  assign o_ready        = (r_state == FILL)   && !i_rst && !i_clear;
  assign o_valid        = (r_state == RESULT) && !i_rst && !i_clear;
  assign w_accept       = i_valid && o_ready;
  assign w_last         = (r_count == INDEX_WIDTH'(N - 1));
  assign w_result_taken = o_valid && i_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_frame
      if (gi == N - 1) begin : g_live
        assign w_frame[gi] = i_value;
      end else begin : g_stored
        assign w_frame[gi] = r_buffer[gi];
      end
    end
  endgenerate

  max_finder #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .N           (N),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_max_finder (
    .i_data  (w_frame),
    .o_index (w_max_idx)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_accept && w_last) w_state_next = RESULT;
      RESULT:  if (w_result_taken)     w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_index <= '0;
      r_value <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_count <= '0;
        r_index <= w_max_idx;
        r_value <= w_frame[w_max_idx];
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buffer[r_count] <= i_value;
    end
  end

  assign o_index = r_index;
  assign o_value = r_value;

endmodule

// File: tb/tb_max_frame_collector.sv
// Scoreboard bench: directed frames on an N=8 instance plus an N=1 instance
// driven with random valid/ready gaps.
module tb_max_frame_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr8, valid8, rdy8;
  logic [7:0] value8;
  logic       o_ready8, o_valid8;
  logic [2:0] idx8;
  logic [7:0] val8;

  logic       clr1, valid1, rdy1;
  logic [7:0] value1;
  logic       o_ready1, o_valid1;
  logic [0:0] idx1;
  logic [7:0] val1;

  max_frame_collector #(.VALUE_WIDTH(8), .N(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr8), .i_valid(valid8), .o_ready(o_ready8),
    .i_value(value8), .o_valid(o_valid8), .i_ready(rdy8), .o_index(idx8), .o_value(val8)
  );

  max_frame_collector #(.VALUE_WIDTH(8), .N(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr1), .i_valid(valid1), .o_ready(o_ready1),
    .i_value(value1), .o_valid(o_valid1), .i_ready(rdy1), .o_index(idx1), .o_value(val1)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] val;
  } exp8_t;

  exp8_t      q8[$];
  logic [7:0] q1[$];
  int         checks   = 0;
  int         errors   = 0;
  int         results1 = 0;
  logic       done1    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop one expectation per completed result handshake.
  always @(negedge clk) begin : mon8
    exp8_t e;
    if (o_valid8 && rdy8) begin
      if (q8.size() == 0) begin
        check("unexpected_result8", 1, 0);
      end else begin
        e = q8.pop_front();
        $display("n8 result: index=%0d value=%0d (expected %0d/%0d)", idx8, val8, e.idx, e.val);
        check("idx8", idx8, e.idx);
        check("val8", val8, e.val);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [7:0] e;
    if (o_valid1 && rdy1) begin
      results1++;
      if (q1.size() == 0) begin
        check("unexpected_result1", 1, 0);
      end else begin
        e = q1.pop_front();
        $display("n1 result: index=%0d value=%0d (expected 0/%0d)", idx1, val1, e);
        check("idx1", idx1, 0);
        check("val1", val1, e);
      end
    end
  end

  task automatic send8(input logic [7:0] v);
    int t;
    t = 0;
    valid8 = 1'b1;
    value8 = v;
    @(negedge clk);
    while (!o_ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send8_timeout", 0, 1);
    else tick();
    valid8 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] v);
    int t;
    t = 0;
    valid1 = 1'b1;
    value1 = v;
    @(negedge clk);
    while (!o_ready1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send1_timeout", 0, 1);
    else tick();
    valid1 = 1'b0;
  endtask

  task automatic send_frame8(input logic [7:0] f [8]);
    for (int i = 0; i < 8; i++) send8(f[i]);
  endtask

  task automatic drain8();
    @(negedge clk);
    tick();
  endtask

  initial begin : stim
    logic [7:0] fr [8];
    logic [7:0] s1 [3];
    int t;

    rst = 1'b1; clr8 = 1'b0; valid8 = 1'b0; rdy8 = 1'b1; value8 = '0;
    clr1 = 1'b0; valid1 = 1'b0; rdy1 = 1'b0; value1 = '0;
    tick();
    @(negedge clk);
    check("ready_during_reset", o_ready8, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", o_valid8, 0);
    check("rst_ready", o_ready8, 1);
    check("rst_index", idx8, 0);
    check("rst_value", val8, 0);
    tick();

    // Tie between slots 1 and 3: lower index wins.
    q8.push_back('{3'd1, 8'd9});
    fr = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd5};
    send_frame8(fr);
    @(negedge clk);
    check("frame_valid", o_valid8, 1);
    check("frame_ready_low", o_ready8, 0);
    tick();
    @(negedge clk);
    check("back_to_fill_ready", o_ready8, 1);
    check("back_to_fill_valid", o_valid8, 0);
    tick();

    q8.push_back('{3'd7, 8'd255});
    fr = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    send_frame8(fr);
    drain8();
    q8.push_back('{3'd0, 8'd0});
    fr = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame8(fr);
    drain8();

    // Back-pressure on the result while the source keeps offering samples.
    rdy8 = 1'b0;
    q8.push_back('{3'd2, 8'd6});
    fr = '{8'd4, 8'd4, 8'd6, 8'd1, 8'd6, 8'd2, 8'd3, 8'd0};
    send_frame8(fr);
    valid8 = 1'b1;
    value8 = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", o_valid8, 1);
      check("hold_ready", o_ready8, 0);
      check("hold_index", idx8, 2);
      check("hold_value", val8, 6);
      tick();
    end
    rdy8 = 1'b1;
    valid8 = 1'b0;
    drain8();
    q8.push_back('{3'd0, 8'd10});
    fr = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame8(fr);
    drain8();

    // Clear mid-frame, then a fresh frame.
    send8(8'd50); send8(8'd60); send8(8'd70); send8(8'd80);
    clr8 = 1'b1;
    valid8 = 1'b1;
    value8 = 8'd200;
    @(negedge clk);
    check("ready_during_clear", o_ready8, 0);
    tick();
    clr8 = 1'b0;
    valid8 = 1'b0;
    @(negedge clk);
    check("clear_valid", o_valid8, 0);
    check("clear_ready", o_ready8, 1);
    tick();
    q8.push_back('{3'd7, 8'd8});
    fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_frame8(fr);
    drain8();

    // Clear while a result is pending with the consumer ready: result is lost.
    rdy8 = 1'b0;
    fr = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    send_frame8(fr);
    @(negedge clk);
    check("pending_before_clear", o_valid8, 1);
    tick();
    clr8 = 1'b1;
    rdy8 = 1'b1;
    @(negedge clk);
    check("valid_during_clear", o_valid8, 0);
    tick();
    clr8 = 1'b0;
    @(negedge clk);
    check("after_clear_valid", o_valid8, 0);
    check("after_clear_ready", o_ready8, 1);
    tick();

    // Reset mid-frame after five samples.
    send8(8'd11); send8(8'd22); send8(8'd33); send8(8'd44); send8(8'd55);
    rst = 1'b1;
    @(negedge clk);
    check("ready_during_rst", o_ready8, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", o_valid8, 0);
    check("rst_mid_index", idx8, 0);
    check("rst_mid_value", val8, 0);
    tick();
    q8.push_back('{3'd1, 8'd200});
    fr = '{8'd9, 8'd200, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    send_frame8(fr);
    drain8();

    // Reset with a result pending.
    rdy8 = 1'b0;
    fr = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd77, 8'd0};
    send_frame8(fr);
    @(negedge clk);
    check("pend_index", idx8, 6);
    check("pend_value", val8, 77);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdy8 = 1'b1;
    @(negedge clk);
    check("rst_pend_valid", o_valid8, 0);
    check("rst_pend_index", idx8, 0);
    check("rst_pend_value", val8, 0);
    tick();
    q8.push_back('{3'd3, 8'd40});
    fr = '{8'd1, 8'd2, 8'd3, 8'd40, 8'd5, 8'd6, 8'd7, 8'd8};
    send_frame8(fr);
    drain8();

    // N=1 instance with random source and sink gaps.
    s1 = '{8'd4, 8'd7, 8'd2};
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          q1.push_back(s1[i]);
          repeat ($urandom_range(0, 3)) tick();
          send1(s1[i]);
        end
        t = 0;
        while (q1.size() != 0 && t < 200) begin
          tick();
          t++;
        end
        done1 = 1'b1;
      end
      begin
        while (!done1) begin
          tick();
          rdy1 = 1'($urandom_range(0, 1));
        end
      end
    join
    rdy1 = 1'b0;
    repeat (3) tick();
    check("n1_drained", q1.size(), 0);
    check("n1_result_count", results1, 3);
    check("n8_drained", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
